regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS instruction-decode stage: the successor to the fixed 32×32, two-read/one-write register file. It adds:

- configurable width, depth and read-port count;
- two write ports with fixed priority;
- same-cycle write-to-read bypass;
- a per-register pending scoreboard, so decode can stall on outstanding producers.

---
 rtl/regfile_mp_pkg.sv | 17 +
 rtl/regfile_mp_rd_port.sv | 62 ++++++
 rtl/regfile_mp.sv | 73 +++++++
 tb/tb_regfile_mp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and read-source encoding for the multi-port MIPS register file.
package regfile_mp_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_READ_PORTS = 2;
  localparam int DEF_ZERO_REG   = 1;
  localparam int NUM_WR_PORTS   = 2;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_WR1,
    SRC_WR0,
    SRC_MEM
  } rd_src_e;

endpackage

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port: zero-register, write bypass (port 1 over port 0), then array.
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AW       = 5,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                          i_reset,
  input  logic [AW-1:0]                 i_addr,
  input  logic [WIDTH-1:0]              i_memWord,
  input  logic                          i_pending,
  input  logic [NUM_WR_PORTS-1:0]       i_wrEn,
  input  logic [NUM_WR_PORTS*AW-1:0]    i_wrAddr,
  input  logic [NUM_WR_PORTS*WIDTH-1:0] i_wrData,
  output logic [WIDTH-1:0]              o_data,
  output logic                          o_ready
);

  rd_src_e w_src;

  always_comb begin
    w_src = SRC_MEM;
    if (ZERO_REG != 0 && i_addr == '0)
      w_src = SRC_ZERO;
    else if (i_wrEn[1] && i_wrAddr[AW +: AW] == i_addr)
      w_src = SRC_WR1;
    else if (i_wrEn[0] && i_wrAddr[0 +: AW] == i_addr)
      w_src = SRC_WR0;
  end

  // Reset masks everything, including bypassed write data, so decode sees a clean zero.
  always_comb begin
    o_data  = '0;
    o_ready = 1'b1;
    if (!i_reset) begin
      unique case (w_src)
        SRC_ZERO: begin
          o_data  = '0;
          o_ready = 1'b1;
        end
        SRC_WR1: begin
          o_data  = i_wrData[WIDTH +: WIDTH];
          o_ready = 1'b1;
        end
        SRC_WR0: begin
          o_data  = i_wrData[0 +: WIDTH];
          o_ready = 1'b1;
        end
        SRC_MEM: begin
          o_data  = i_memWord;
          o_ready = ~i_pending;
        end
        default: begin
          o_data  = '0;
          o_ready = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: storage array, pending scoreboard and write/alloc sequencing.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [READ_PORTS*AW-1:0]      rd_addr,
  output logic [READ_PORTS*WIDTH-1:0]   rd_data,
  output logic [READ_PORTS-1:0]         rd_ready,
  input  logic [NUM_WR_PORTS-1:0]       wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]    wr_addr,
  input  logic [NUM_WR_PORTS*WIDTH-1:0] wr_data,
  input  logic                          alloc_en,
  input  logic [AW-1:0]                 alloc_addr
);

  logic [WIDTH-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]        r_pending;
  logic [NUM_WR_PORTS-1:0] w_wrKeep;
  logic                    w_allocKeep;

  always_comb begin
    for (int k = 0; k < NUM_WR_PORTS; k++)
      w_wrKeep[k] = wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*AW +: AW] == '0);
    w_allocKeep = alloc_en && !(ZERO_REG != 0 && alloc_addr == '0);
  end

  // Later assignments win: port 1 overrides port 0, and alloc overrides the pending clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_pending <= '0;
    end else begin
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (w_wrKeep[k]) begin
          r_mem[wr_addr[k*AW +: AW]]     <= wr_data[k*WIDTH +: WIDTH];
          r_pending[wr_addr[k*AW +: AW]] <= 1'b0;
        end
      end
      if (w_allocKeep)
        r_pending[alloc_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = rd_addr[i*AW +: AW];

    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .i_reset   (reset),
      .i_addr    (w_addr),
      .i_memWord (r_mem[w_addr]),
      .i_pending (r_pending[w_addr]),
      .i_wrEn    (wr_en),
      .i_wrAddr  (wr_addr),
      .i_wrData  (wr_data),
      .o_data    (rd_data[i*WIDTH +: WIDTH]),
      .o_ready   (rd_ready[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x32/2-port instance plus a 8x16/3-port instance.
module tb_regfile_mp;

  typedef struct packed {
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][31:0] wd;
    logic             ae;
    logic [4:0]       aa;
    logic [2:0][4:0]  ra;
  } stim_t;

  typedef struct packed {
    logic        dut;
    logic [1:0]  port;
    logic [31:0] data;
    logic        ready;
    logic [7:0]  phase;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [9:0]  aRdAddr;
  logic [63:0] aRdData;
  logic [1:0]  aRdReady;
  logic [1:0]  aWrEn;
  logic [9:0]  aWrAddr;
  logic [63:0] aWrData;
  logic        aAllocEn;
  logic [4:0]  aAllocAddr;

  logic [8:0]  bRdAddr;
  logic [47:0] bRdData;
  logic [2:0]  bRdReady;
  logic [1:0]  bWrEn;
  logic [5:0]  bWrAddr;
  logic [31:0] bWrData;
  logic        bAllocEn;
  logic [2:0]  bAllocAddr;

  int errors = 0;
  int checks = 0;
  exp_t sbQ[$];

  logic [31:0] mMem  [2][32];
  logic        mPend [2][32];

  always #5 clk = ~clk;

  regfile_mp dutA (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (aRdAddr),
    .rd_data    (aRdData),
    .rd_ready   (aRdReady),
    .wr_en      (aWrEn),
    .wr_addr    (aWrAddr),
    .wr_data    (aWrData),
    .alloc_en   (aAllocEn),
    .alloc_addr (aAllocAddr)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(8), .READ_PORTS(3)) dutB (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (bRdAddr),
    .rd_data    (bRdData),
    .rd_ready   (bRdReady),
    .wr_en      (bWrEn),
    .wr_addr    (bWrAddr),
    .wr_data    (bWrData),
    .alloc_en   (bAllocEn),
    .alloc_addr (bAllocAddr)
  );

  function automatic int depthOf(input int d);
    return (d != 0) ? 8 : 32;
  endfunction

  function automatic logic [31:0] maskOf(input int d);
    return (d != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Reference read: reset forces 0/ready, r0 reads 0/ready, newest write bypasses, else stored value.
  function automatic void expRead(input int d, input logic rst, input stim_t s, input int p,
                                  output logic [31:0] ed, output logic er);
    int a;
    a  = int'(s.ra[p]) % depthOf(d);
    ed = 32'h0;
    er = 1'b1;
    if (rst || a == 0) begin
      ed = 32'h0;
      er = 1'b1;
    end else if (s.we[1] && int'(s.wa[1]) % depthOf(d) == a) begin
      ed = s.wd[1] & maskOf(d);
    end else if (s.we[0] && int'(s.wa[0]) % depthOf(d) == a) begin
      ed = s.wd[0] & maskOf(d);
    end else begin
      ed = mMem[d][a];
      er = !mPend[d][a];
    end
  endfunction

  // Reference state change at a clock edge.
  function automatic void modelUpdate(input int d, input logic rst, input stim_t s);
    int a;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mMem[d][i]  = 32'h0;
        mPend[d][i] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        a = int'(s.wa[k]) % depthOf(d);
        if (s.we[k] && a != 0) begin
          mMem[d][a]  = s.wd[k] & maskOf(d);
          mPend[d][a] = 1'b0;
        end
      end
      a = int'(s.aa) % depthOf(d);
      if (s.ae && a != 0)
        mPend[d][a] = 1'b1;
    end
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t randStim(input int d);
    stim_t s;
    int hi;
    s  = '0;
    hi = depthOf(d) - 1;
    for (int k = 0; k < 2; k++) begin
      s.we[k] = ($urandom_range(0, 1) == 1);
      s.wa[k] = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, hi) : $urandom_range(0, 7));
      s.wd[k] = $urandom;
    end
    s.ae = ($urandom_range(0, 2) == 0);
    s.aa = 5'($urandom_range(0, 7));
    for (int p = 0; p < 3; p++)
      s.ra[p] = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, hi) : $urandom_range(0, 7));
    return s;
  endfunction

  // Drives one cycle, queues the expected reads for that cycle, then advances the model at the edge.
  task automatic applyStimulus(input stim_t sA, input stim_t sB, input logic rst, input int phase);
    exp_t e;
    reset      = rst;
    aWrEn      = sA.we;
    aWrAddr    = {sA.wa[1], sA.wa[0]};
    aWrData    = {sA.wd[1], sA.wd[0]};
    aAllocEn   = sA.ae;
    aAllocAddr = sA.aa;
    aRdAddr    = {sA.ra[1], sA.ra[0]};
    bWrEn      = sB.we;
    bWrAddr    = {sB.wa[1][2:0], sB.wa[0][2:0]};
    bWrData    = {sB.wd[1][15:0], sB.wd[0][15:0]};
    bAllocEn   = sB.ae;
    bAllocAddr = sB.aa[2:0];
    bRdAddr    = {sB.ra[2][2:0], sB.ra[1][2:0], sB.ra[0][2:0]};
    for (int p = 0; p < 2; p++) begin
      e.dut = 1'b0; e.port = 2'(p); e.phase = 8'(phase);
      expRead(0, rst, sA, p, e.data, e.ready);
      sbQ.push_back(e);
    end
    for (int p = 0; p < 3; p++) begin
      e.dut = 1'b1; e.port = 2'(p); e.phase = 8'(phase);
      expRead(1, rst, sB, p, e.data, e.ready);
      sbQ.push_back(e);
    end
    @(posedge clk);
    modelUpdate(0, rst, sA);
    modelUpdate(1, rst, sB);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] actD;
    logic        actR;
    if (e.dut == 1'b0) begin
      actD = aRdData[int'(e.port)*32 +: 32];
      actR = aRdReady[e.port];
    end else begin
      actD = {16'h0, bRdData[int'(e.port)*16 +: 16]};
      actR = bRdReady[e.port];
    end
    checks++;
    if (actD !== e.data || actR !== e.ready) begin
      errors++;
      $display("[TB] FAIL read phase%0d dut%0d port%0d: got data=%h ready=%b, want data=%h ready=%b",
               e.phase, e.dut, e.port, actD, actR, e.data, e.ready);
    end
  endtask

  always @(negedge clk) begin
    while (sbQ.size() > 0)
      checkOutput(sbQ.pop_front());
  end

  initial begin
    stim_t sA, sB;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin
        mMem[d][i]  = 32'h0;
        mPend[d][i] = 1'b0;
      end
    aWrEn = '0; aWrAddr = '0; aWrData = '0; aAllocEn = 1'b0; aAllocAddr = '0; aRdAddr = '0;
    bWrEn = '0; bWrAddr = '0; bWrData = '0; bAllocEn = 1'b0; bAllocAddr = '0; bRdAddr = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles; a write and alloc issued under reset must be dropped.
    sB = idleStim();
    sB.ra[0] = 5'd3; sB.ra[1] = 5'd7; sB.we = 2'b01; sB.wa[0] = 5'd3; sB.wd[0] = 32'hBEEF;
    sA = idleStim(); sA.ra[0] = 5'd5; sA.ra[1] = 5'd31;
    applyStimulus(sA, sB, 1'b1, 1);
    sA.ra[0] = 5'd0; sA.we = 2'b01; sA.wa[0] = 5'd5; sA.wd[0] = 32'hFFFF_FFFF;
    sA.ae = 1'b1; sA.aa = 5'd31;
    applyStimulus(sA, sB, 1'b1, 1);
    sA = idleStim(); sA.ra[0] = 5'd5; sA.ra[1] = 5'd31;
    sB = idleStim(); sB.ra[0] = 5'd3; sB.ra[2] = 5'd7;
    applyStimulus(sA, sB, 1'b0, 2);

    sB = idleStim();
    sA = idleStim(); sA.we = 2'b01; sA.wa[0] = 5'd4; sA.wd[0] = 32'h5; sA.ra[0] = 5'd4;
    applyStimulus(sA, sB, 1'b0, 3);
    sA = idleStim(); sA.ra[0] = 5'd4; sA.ra[1] = 5'd1;
    applyStimulus(sA, sB, 1'b0, 3);

    sA = idleStim(); sA.we = 2'b11; sA.wa[0] = 5'd7; sA.wa[1] = 5'd7;
    sA.wd[0] = 32'hAAAA; sA.wd[1] = 32'h5555; sA.ra[0] = 5'd7; sA.ra[1] = 5'd4;
    applyStimulus(sA, sB, 1'b0, 4);
    sA = idleStim(); sA.ra[0] = 5'd7; sA.ra[1] = 5'd7;
    applyStimulus(sA, sB, 1'b0, 4);

    sA = idleStim(); sA.we = 2'b10; sA.wa[1] = 5'd0; sA.wd[1] = 32'hDEAD_BEEF;
    sA.ae = 1'b1; sA.aa = 5'd0;
    applyStimulus(sA, sB, 1'b0, 5);
    sA = idleStim();
    applyStimulus(sA, sB, 1'b0, 5);

    sA = idleStim(); sA.ae = 1'b1; sA.aa = 5'd9; sA.ra[0] = 5'd9;
    applyStimulus(sA, sB, 1'b0, 6);
    sA = idleStim(); sA.ra[0] = 5'd9; sA.ra[1] = 5'd9;
    applyStimulus(sA, sB, 1'b0, 6);
    sA = idleStim(); sA.we = 2'b10; sA.wa[1] = 5'd9; sA.wd[1] = 32'h1234; sA.ra[1] = 5'd9;
    applyStimulus(sA, sB, 1'b0, 6);
    sA = idleStim(); sA.ra[0] = 5'd9;
    applyStimulus(sA, sB, 1'b0, 6);
    sA = idleStim(); sA.ae = 1'b1; sA.aa = 5'd9; sA.we = 2'b01; sA.wa[0] = 5'd9;
    sA.wd[0] = 32'h1234; sA.ra[0] = 5'd9;
    applyStimulus(sA, sB, 1'b0, 6);
    sA = idleStim(); sA.ra[0] = 5'd9; sA.ra[1] = 5'd9;
    applyStimulus(sA, sB, 1'b0, 6);

    sA = idleStim(); sA.we = 2'b01; sA.wa[0] = 5'd3; sA.wd[0] = 32'h77;
    applyStimulus(sA, sB, 1'b0, 7);
    sA = idleStim(); sA.ae = 1'b1; sA.aa = 5'd3; sA.ra[0] = 5'd3;
    applyStimulus(sA, sB, 1'b0, 7);
    sA = idleStim(); sA.ra[0] = 5'd3;
    applyStimulus(sA, sB, 1'b0, 7);
    sA = idleStim(); sA.we = 2'b01; sA.wa[0] = 5'd3; sA.wd[0] = 32'h99; sA.ra[0] = 5'd3;
    applyStimulus(sA, sB, 1'b1, 7);
    sA = idleStim(); sA.ra[0] = 5'd3; sA.ra[1] = 5'd9;
    applyStimulus(sA, sB, 1'b0, 7);

    for (int n = 0; n < 400; n++)
      applyStimulus(randStim(0), randStim(1), ($urandom_range(0, 63) == 0), 8);

    @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
